mul_share_arbiter: RTL

Shares one pipelined 15x15 signed multiplier (3 register stages, all stages gated by a single ce, no reset on data registers) between NUM_REQ requesters. The block performs round-robin arbitration, issues one operand pair per cycle, and tracks in-flight operations with a tag pipeline aligned to the multiplier latency. Each result is returned to its originating requester. Per-requester response backpressure is applied by stalling the whole multiplier through ce. It sits between the controller FSMs and the shared multiplier instance.

---
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/mul_share_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the requesters and mul_share_arbiter.
//   req_valid/req_ready : per-requester operation handshake (ready is one-hot)
//   req_a/req_b         : packed signed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready : per-requester result handshake (valid is one-hot)
//   rsp_data            : shared result bus, qualified by rsp_valid
// master = requester side, slave = arbiter side.
interface mul_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 15
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ
// requesters. One operand pair is issued per cycle; a tag pipeline of
// MUL_LAT stages tracks which requester owns each in-flight product so the
// result is routed back with a one-hot rsp_valid. A result that its owner
// will not accept freezes the multiplier and the tag pipe via mul_ce.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : request/response bundle, see mul_share_arbiter_if
//   mul_ce              : multiplier clock enable (all stages)
//   mul_din0, mul_din1  : operands of the granted requester (0 when no grant)
//   mul_dout            : low DATA_W bits of the product, MUL_LAT ce-clocks later
//   busy                : any tag stage holds a live operation
// NUM_REQ and DATA_W must match the parameters of the connected interface.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 15,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    mul_share_arbiter_if.slave bus,
    output logic              mul_ce,
    output logic [DATA_W-1:0] mul_din0,
    output logic [DATA_W-1:0] mul_din1,
    input  logic [DATA_W-1:0] mul_dout,
    output logic              busy
);

    logic [ID_W-1:0]    ptr;
    logic [MUL_LAT-1:0] tag_valid;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    logic               out_valid;
    logic [ID_W-1:0]    out_id;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic               issue;

    assign out_valid = tag_valid[MUL_LAT-1];
    assign out_id    = tag_id[MUL_LAT-1];

    // Freeze everything while the head result waits for its owner.
    assign mul_ce = ~(out_valid & ~bus.rsp_ready[out_id]);

    // Search upward from the requester after the last one served.
    // The grant is suppressed while reset is asserted so req_ready stays low.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!grant_found && reset_n && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign issue = grant_found & mul_ce;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_found && grant_id == ID_W'(i)) begin
                mul_din0 = bus.req_a[i*DATA_W +: DATA_W];
                mul_din1 = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (issue) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        if (out_valid) begin
            bus.rsp_valid[out_id] = 1'b1;
        end
    end

    assign bus.rsp_data = mul_dout;
    assign busy         = |tag_valid;

    // Tag pipe advances in lockstep with the multiplier; a cycle with no
    // issue shifts in a bubble so stale multiplier data is never reported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= ID_W'(NUM_REQ - 1);
            tag_valid <= '0;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else if (mul_ce) begin
            tag_valid <= {tag_valid[MUL_LAT-2:0], issue};
            tag_id[0] <= grant_id;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (issue) begin
                ptr <= grant_id;
            end
        end
    end

endmodule
